// File: rtl/byte_lane_data_memory.sv
// Byte-lane data memory for the MIPS datapath: byte/half/word stores with lane enables,
// sign/zero-extended registered loads, alignment and range flags, optional clear-on-reset.
module byte_lane_data_memory #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH_WORDS    = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [1:0]            size,
    input  logic                  signedLoad,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    output logic                  ready,
    output logic [31:0]           readData,
    output logic                  readValid,
    output logic                  misaligned,
    output logic                  outOfRange
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [ADDR_WIDTH-2:0] DEPTH_LIM = (ADDR_WIDTH-1)'(DEPTH_WORDS);

    // Handshake: a request is taken at a posedge when ready=1 and memRead|memWrite=1;
    // its result (readValid / error pulse) appears for exactly the following cycle.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [31:0]      mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-3:0] wordIdx;
    logic [IDX_W-1:0]      memIdx;
    logic [1:0]            lane;
    logic                  accept;
    logic                  bothReq;
    logic                  misalignedReq;
    logic                  outOfRangeReq;
    logic                  legal;
    logic [3:0]            laneMask;
    logic [31:0]           laneData;
    logic [31:0]           rawWord;
    logic [31:0]           shifted;
    logic [31:0]           loadValue;
    logic                  wrEn;
    logic [IDX_W-1:0]      wrIdx;
    logic [31:0]           wrData;
    logic [3:0]            wrMask;

    assign wordIdx       = address[ADDR_WIDTH-1:2];
    assign memIdx        = wordIdx[IDX_W-1:0];
    assign lane          = address[1:0];
    assign accept        = ready & (memRead | memWrite);
    assign bothReq       = memRead & memWrite;
    assign outOfRangeReq = ({1'b0, wordIdx} >= DEPTH_LIM);
    assign legal         = !misalignedReq && !outOfRangeReq;
    assign rawWord       = mem[memIdx];
    assign shifted       = rawWord >> {lane, 3'b000};

    always_comb begin
        misalignedReq = 1'b0;
        laneMask      = 4'b0000;
        laneData      = writeData;
        loadValue     = rawWord;
        case (size)
            2'b00: begin
                laneMask  = 4'b0001 << lane;
                laneData  = {4{writeData[7:0]}};
                loadValue = signedLoad ? {{24{shifted[7]}}, shifted[7:0]}
                                       : {24'b0, shifted[7:0]};
            end
            2'b01: begin
                misalignedReq = address[0];
                laneMask      = address[1] ? 4'b1100 : 4'b0011;
                laneData      = {2{writeData[15:0]}};
                loadValue     = signedLoad ? {{16{shifted[15]}}, shifted[15:0]}
                                           : {16'b0, shifted[15:0]};
            end
            2'b10: begin
                misalignedReq = |address[1:0];
                laneMask      = 4'b1111;
            end
            default: misalignedReq = 1'b1;
        endcase
    end

    // The clear sequence and normal stores share one write port.
    always_comb begin
        wrEn   = 1'b0;
        wrIdx  = memIdx;
        wrData = laneData;
        wrMask = laneMask;
        if (state == ST_INIT) begin
            if (CLEAR_ON_RESET) begin
                wrEn   = !Reset;
                wrIdx  = ptr;
                wrData = 32'b0;
                wrMask = 4'b1111;
            end
        end else begin
            wrEn = !Reset && accept && memWrite && !memRead && legal;
        end
    end

    always_ff @(posedge Clk) begin
        if (wrEn) begin
            for (int k = 0; k < 4; k++) begin
                if (wrMask[k]) begin
                    mem[wrIdx][8*k +: 8] <= wrData[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_INIT;
            ptr        <= '0;
            ready      <= 1'b0;
            readData   <= 32'b0;
            readValid  <= 1'b0;
            misaligned <= 1'b0;
            outOfRange <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    readValid  <= 1'b0;
                    misaligned <= 1'b0;
                    outOfRange <= 1'b0;
                    if (!CLEAR_ON_RESET || ptr == LAST_IDX) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    ready      <= 1'b1;
                    readValid  <= accept && memRead;
                    // A simultaneous read+write is rejected silently, never flagged.
                    misaligned <= accept && !bothReq && misalignedReq;
                    outOfRange <= accept && !bothReq && !misalignedReq && outOfRangeReq;
                    if (accept && memRead) begin
                        readData <= (bothReq || !legal) ? 32'b0 : loadValue;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    ptr   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_lane_data_memory.sv
// Self-checking bench for byte_lane_data_memory: directed loads/stores, error flags,
// clear-on-reset timing; responses checked by a scoreboard monitor.
module tb_byte_lane_data_memory;

    logic        clk = 1'b0;
    logic        Reset;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  size;
    logic        signedLoad;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        ready;
    logic [31:0] readData;
    logic        readValid;
    logic        misaligned;
    logic        outOfRange;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Expected response: {readData, readValid, misaligned, outOfRange}
    logic [34:0] exp_q[$];
    string       name_q[$];
    logic [31:0] last_rd = 32'b0;

    always #5 clk = ~clk;

    byte_lane_data_memory #(
        .ADDR_WIDTH    (32),
        .DEPTH_WORDS   (64),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .Clk       (clk),
        .Reset     (Reset),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .size      (size),
        .signedLoad(signedLoad),
        .address   (address),
        .writeData (writeData),
        .ready     (ready),
        .readData  (readData),
        .readValid (readValid),
        .misaligned(misaligned),
        .outOfRange(outOfRange)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if ((readValid | misaligned | outOfRange) === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output: got %h expected no pulse",
                         {readData, readValid, misaligned, outOfRange});
            end else begin
                check(name_q.pop_front(), {29'b0, readData, readValid, misaligned, outOfRange},
                      {29'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic req(input string nm, input bit rd, input bit wr, input logic [1:0] sz,
                       input bit sgn, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input bit exp_mis, input bit exp_oor);
        @(negedge clk);
        memRead    = rd;
        memWrite   = wr;
        size       = sz;
        signedLoad = sgn;
        address    = addr;
        writeData  = wd;
        if (rd) last_rd = exp_data;
        if (rd || exp_mis || exp_oor) begin
            exp_q.push_back({last_rd, rd, exp_mis, exp_oor});
            name_q.push_back(nm);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d outstanding responses expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic wait_ready(input string nm, input int exp_cycles);
        int n;
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (ready === 1'b1) break;
        end
        check(nm, 64'(n), 64'(exp_cycles));
    endtask

    initial begin
        Reset      = 1'b1;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        size       = 2'b10;
        signedLoad = 1'b0;
        address    = 32'h0;
        writeData  = 32'h0;

        // T1: one-cycle reset, clear sequence, first reads
        @(negedge clk);
        check("reset_outputs", {30'b0, ready, readData, readValid, misaligned, outOfRange}, 64'h0);
        Reset = 1'b0;
        wait_ready("t1_ready_latency", 64);
        req("t1_lw_0x00", 1, 0, 2'b10, 0, 32'h00, 32'h0, 32'h0, 0, 0);
        req("t1_lw_0xFC", 1, 0, 2'b10, 0, 32'hFC, 32'h0, 32'h0, 0, 0);

        // T2: word store, byte overwrite, single-cycle readValid and hold
        req("t2_sw_0x10", 0, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 0);
        req("t2_sb_0x12", 0, 1, 2'b00, 0, 32'h12, 32'h000000AA, 32'h0, 0, 0);
        req("t2_lw_0x10", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h11AA3344, 0, 0);
        idle();
        @(negedge clk);
        check("t2_readValid_one_cycle", {63'b0, readValid}, 64'h0);
        check("t2_readData_hold", {32'b0, readData}, 64'h11AA3344);

        // T3: halfword/byte stores and extended loads
        req("t3_sh_0x22", 0, 1, 2'b01, 0, 32'h22, 32'h12348001, 32'h0, 0, 0);
        req("t3_lh_0x22", 1, 0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFF8001, 0, 0);
        req("t3_lhu_0x22", 1, 0, 2'b01, 0, 32'h22, 32'h0, 32'h00008001, 0, 0);
        req("t3_lb_0x23", 1, 0, 2'b00, 1, 32'h23, 32'h0, 32'hFFFFFF80, 0, 0);
        req("t3_lbu_0x22", 1, 0, 2'b00, 0, 32'h22, 32'h0, 32'h00000001, 0, 0);
        req("t3_lw_0x20", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h80010000, 0, 0);
        req("t3_sh_0x24", 0, 1, 2'b01, 0, 32'h24, 32'h0000BEEF, 32'h0, 0, 0);
        req("t3_lh_0x24", 1, 0, 2'b01, 1, 32'h24, 32'h0, 32'hFFFFBEEF, 0, 0);
        req("t3_lw_0x24", 1, 0, 2'b10, 1, 32'h24, 32'h0, 32'h0000BEEF, 0, 0);
        req("t3_sb_0x30", 0, 1, 2'b00, 0, 32'h30, 32'hABCD127F, 32'h0, 0, 0);
        req("t3_lb_0x30", 1, 0, 2'b00, 1, 32'h30, 32'h0, 32'h0000007F, 0, 0);
        req("t3_lh_0x30", 1, 0, 2'b01, 1, 32'h30, 32'h0, 32'h0000007F, 0, 0);

        // T4: misaligned stores and loads
        req("t4_sw_0x06", 0, 1, 2'b10, 0, 32'h06, 32'hDEADBEEF, 32'h0, 1, 0);
        req("t4_lw_0x04", 1, 0, 2'b10, 0, 32'h04, 32'h0, 32'h0, 0, 0);
        req("t4_lh_0x05", 1, 0, 2'b01, 1, 32'h05, 32'h0, 32'h0, 1, 0);
        req("t4_size11_0x08", 1, 0, 2'b11, 0, 32'h08, 32'h0, 32'h0, 1, 0);
        req("t4_lw_0x02", 1, 0, 2'b10, 0, 32'h02, 32'h0, 32'h0, 1, 0);
        req("t4_lw_0x10_prime", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h11AA3344, 0, 0);
        req("t4_sh_0x13", 0, 1, 2'b01, 0, 32'h13, 32'h0000FFFF, 32'h0, 1, 0);
        req("t4_lw_0x10", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h11AA3344, 0, 0);

        // T5: out-of-range accesses and the last valid word
        req("t5_lw_0x100", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h0, 0, 1);
        req("t5_sw_0x100", 0, 1, 2'b10, 0, 32'h100, 32'h55555555, 32'h0, 0, 1);
        req("t5_lw_0x00", 1, 0, 2'b10, 0, 32'h00, 32'h0, 32'h0, 0, 0);
        req("t5_lh_0x101", 1, 0, 2'b01, 0, 32'h101, 32'h0, 32'h0, 1, 0);
        req("t5_sw_0xFC", 0, 1, 2'b10, 0, 32'hFC, 32'hCAFEF00D, 32'h0, 0, 0);
        req("t5_lw_0xFC", 1, 0, 2'b10, 0, 32'hFC, 32'h0, 32'hCAFEF00D, 0, 0);
        req("t5_lb_0xFF", 1, 0, 2'b00, 1, 32'hFF, 32'h0, 32'hFFFFFFCA, 0, 0);
        drain();

        // T6: reset in RUN drops the in-flight read, then reset mid-clear
        @(negedge clk);
        Reset   = 1'b1;
        memRead = 1'b1;
        size    = 2'b10;
        address = 32'h10;
        @(negedge clk);
        memRead = 1'b0;
        check("t6_run_reset_drop", {30'b0, ready, readData, readValid, misaligned, outOfRange}, 64'h0);
        Reset   = 1'b0;
        last_rd = 32'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t6_mid_init_not_ready", {63'b0, ready}, 64'h0);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        wait_ready("t6_ready_after_restart", 64);
        req("t6_lw_0x10_cleared", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 0);
        req("t6_lw_0x20_cleared", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, 0);
        req("t6_lw_0x24_cleared", 1, 0, 2'b10, 0, 32'h24, 32'h0, 32'h0, 0, 0);
        req("t6_lw_0xFC_cleared", 1, 0, 2'b10, 0, 32'hFC, 32'h0, 32'h0, 0, 0);
        req("t6_sw_0x00", 0, 1, 2'b10, 0, 32'h00, 32'h0000ABCD, 32'h0, 0, 0);
        req("t6_rw_both_0x00", 1, 1, 2'b10, 0, 32'h00, 32'hFFFFFFFF, 32'h0, 0, 0);
        req("t6_lw_0x00_unchanged", 1, 0, 2'b10, 0, 32'h00, 32'h0, 32'h0000ABCD, 0, 0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
